// File: rtl/syzygy_adc_pkg.sv
// Shared constants and types for the SYZYGY ADC word-alignment logic.
// Covers lane geometry, the default frame pattern and the alignment FSM states.
package syzygy_adc_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 2;
    localparam int DATA_W    = LANE_W * NUM_LANES;

    // LTC2264-12 frame lane in 1:8 deserialization: four ones, four zeros.
    localparam logic [LANE_W-1:0] FRAME_PATTERN_DEFAULT = 8'hF0;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/syzygy_adc_frame_align.sv
// Frame-lane word aligner in the ISERDES CLKDIV domain: bitslips until the frame
// word matches, confirms and monitors lock, and registers the data lanes.
module syzygy_adc_frame_align
    import syzygy_adc_pkg::*;
#(
    parameter logic [LANE_W-1:0] FRAME_PATTERN = FRAME_PATTERN_DEFAULT,
    parameter int unsigned       SLIP_WAIT     = 8,
    parameter int unsigned       LOCK_COUNT    = 16,
    parameter int unsigned       ERR_LIMIT     = 4,
    parameter int unsigned       MAX_SLIPS     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              realign,
    input  logic [LANE_W-1:0] frame_data,
    input  logic [DATA_W-1:0] data_in,
    output logic              bitslip,
    output logic              locked,
    output logic              align_error,
    output logic [3:0]        slip_count,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int WAIT_W  = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

    localparam logic [WAIT_W-1:0]  WAIT_RELOAD = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [MATCH_W-1:0] LOCK_C      = MATCH_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]   ERR_C       = ERR_W'(ERR_LIMIT);
    localparam logic [3:0]         MAX_SLIPS_C = 4'(MAX_SLIPS);

    align_state_e        state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [3:0]          slip_count_q, slip_count_d;
    logic                bitslip_q, locked_q, align_error_q, data_valid_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                frame_ok;

    assign frame_ok = (frame_data == FRAME_PATTERN);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        match_cnt_d  = match_cnt_q;
        err_cnt_d    = err_cnt_q;
        slip_count_d = slip_count_q;

        if (realign) begin
            state_d      = ST_WAIT;
            wait_cnt_d   = WAIT_RELOAD;
            match_cnt_d  = '0;
            err_cnt_d    = '0;
            slip_count_d = '0;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (wait_cnt_q == '0) state_d = ST_CHECK;
                    else                  wait_cnt_d = wait_cnt_q - 1'b1;
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        match_cnt_d = MATCH_W'(1);
                        err_cnt_d   = '0;
                        state_d     = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end else if (slip_count_q == MAX_SLIPS_C) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d      = ST_SLIP;
                        slip_count_d = sat_inc4(slip_count_q);
                    end
                end
                ST_VERIFY: begin
                    if (frame_ok) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == LOCK_C) begin
                            state_d   = ST_LOCKED;
                            err_cnt_d = '0;
                        end
                    end else if (slip_count_q == MAX_SLIPS_C) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d      = ST_SLIP;
                        slip_count_d = sat_inc4(slip_count_q);
                    end
                end
                ST_SLIP: begin
                    state_d     = ST_WAIT;
                    wait_cnt_d  = WAIT_RELOAD;
                    match_cnt_d = '0;
                end
                ST_LOCKED: begin
                    if (frame_ok) begin
                        err_cnt_d = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                        // Lock is dropped quietly: the next attempt restarts without slipping.
                        if (err_cnt_d == ERR_C) begin
                            state_d      = ST_WAIT;
                            wait_cnt_d   = WAIT_RELOAD;
                            match_cnt_d  = '0;
                            err_cnt_d    = '0;
                            slip_count_d = '0;
                        end
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_RELOAD;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            wait_cnt_q    <= WAIT_RELOAD;
            match_cnt_q   <= '0;
            err_cnt_q     <= '0;
            slip_count_q  <= '0;
            bitslip_q     <= 1'b0;
            locked_q      <= 1'b0;
            align_error_q <= 1'b0;
            data_valid_q  <= 1'b0;
            data_out_q    <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            match_cnt_q   <= match_cnt_d;
            err_cnt_q     <= err_cnt_d;
            slip_count_q  <= slip_count_d;
            // Outputs decode the next state so they track state_q exactly, glitch-free.
            bitslip_q     <= (state_d == ST_SLIP);
            locked_q      <= (state_d == ST_LOCKED);
            align_error_q <= (state_d == ST_FAIL);
            data_valid_q  <= (state_d == ST_LOCKED);
            data_out_q    <= data_in;
        end
    end

    assign bitslip     = bitslip_q;
    assign locked      = locked_q;
    assign align_error = align_error_q;
    assign slip_count  = slip_count_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;

endmodule

// File: doc/syzygy_adc_frame_align.md
Name: syzygy_adc_frame_align

Overview:
Word-alignment stage that sits directly downstream of the ADC DCO clocking block. It runs in the divided (1/4-rate) clock domain that clocks the ISERDES parallel outputs. It watches the deserialized frame (FR) lane, issues ISERDES bitslip pulses until the frame word matches the expected pattern, then confirms lock and monitors it. It also registers the two data-lane words and marks them valid while locked.

Parameters:
FRAME_PATTERN, 8'hF0, expected deserialized frame-lane word when aligned
SLIP_WAIT, 8, settle cycles after each bitslip before re-checking (must be >=2)
LOCK_COUNT, 16, consecutive matching frame words required to declare lock
ERR_LIMIT, 4, consecutive mismatches in LOCKED before lock is dropped
MAX_SLIPS, 15, bitslips allowed per alignment attempt before FAIL (max 15)

Ports:
clk  in  1  divided ADC clock (ISERDES CLKDIV domain)
reset  in  1  asynchronous, active-high
realign  in  1  single-cycle request to restart alignment
frame_data  in  8  ISERDES output word from the FR lane
data_in  in  16  ISERDES output words, {lane1[7:0], lane0[7:0]}
bitslip  out  1  one-cycle pulse to all ISERDES BITSLIP inputs
locked  out  1  alignment achieved and held
align_error  out  1  alignment attempt exhausted MAX_SLIPS
slip_count  out  4  bitslips issued in current attempt (saturates at 15)
data_out  out  16  registered data_in
data_valid  out  1  data_out is framed-aligned data

Behaviour:
- Reset (async assert, release synchronous to clk): state=WAIT, wait counter=SLIP_WAIT-1. All outputs 0.
- States: WAIT, CHECK, SLIP, VERIFY, LOCKED, FAIL.
- WAIT: decrement wait counter; at 0 go to CHECK next cycle. Total WAIT dwell is SLIP_WAIT cycles.
- CHECK: compare frame_data to FRAME_PATTERN.
  - Match -> VERIFY, match count=1.
  - Mismatch with slip_count==MAX_SLIPS -> FAIL.
  - Otherwise mismatch -> SLIP.
- SLIP: bitslip=1 for exactly this cycle; slip_count+1; then WAIT with counter reloaded. Bitslip pulses are therefore spaced at least SLIP_WAIT+2 cycles apart and are never back-to-back.
- VERIFY: compare every cycle.
  - Mismatch -> SLIP (or FAIL if slip_count==MAX_SLIPS).
  - Match increments match count; when it reaches LOCK_COUNT -> LOCKED.
  - CHECK plus VERIFY together consume exactly LOCK_COUNT consecutive matching words.
- LOCKED: locked=1.
  - Consecutive-mismatch counter increments on mismatch and clears on any match.
  - Reaching ERR_LIMIT -> WAIT with locked=0 the next cycle, slip_count cleared, no bitslip issued.
  - Isolated mismatches below ERR_LIMIT do not drop lock.
- FAIL: align_error=1, bitslip held 0. Stays in FAIL until realign or reset.
- realign=1 in any state, including mid-WAIT or the cycle a SLIP would occur:
  - Takes priority over every other transition.
  - Next state is WAIT with counter reloaded.
  - slip_count, match count and error count are cleared; locked and align_error go to 0.
  - No bitslip is issued in that cycle.
- locked is a registered state decode (high exactly while state==LOCKED). align_error is high exactly while state==FAIL.
- data_out <= data_in every cycle (1-cycle latency, regardless of state). data_valid <= (next state == LOCKED), so data_valid and locked rise and fall on the same edge.
- slip_count saturates at 15 and never wraps.

Decomposition:
- Shared package syzygy_adc_pkg holds:
  - the state enumeration constants (3-bit encoding);
  - the default LTC2264-12 frame pattern 8'hF0;
  - the lane/word width constants (8-bit lane, 2 lanes).
- Single module. A sub-module is not needed; the settle counter stays inline.

Test Plan:
- Reset, then frame_data=8'hF0 constantly -> no bitslip; after SLIP_WAIT+LOCK_COUNT cycles (24) locked=1, data_valid=1, slip_count=0.
- frame_data=8'h1E (rotated) until 3 bitslips seen, then 8'hF0 -> exactly 3 pulses each spaced >=10 cycles; locked=1, slip_count=3.
- frame_data never matches -> exactly 15 bitslip pulses, then align_error=1, locked=0, bitslip stays 0 for 200 further cycles.
- In LOCKED, inject 3 mismatches, one match, then 3 mismatches -> lock held. Then inject 4 consecutive mismatches -> locked and data_valid fall 1 cycle after the 4th.
- In FAIL, pulse realign -> align_error=0, slip_count=0 next cycle; frame_data=8'hF0 -> relock in 24 cycles.
- Assert reset mid-SLIP and mid-LOCKED -> all outputs 0 asynchronously; realign coincident with the SLIP-decision cycle -> no bitslip pulse emitted.
